// File: rtl/mdu.sv
// mdu: iterative RV32M multiply/divide unit, 32 cycles per op with start/done handshake.
module mdu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        kill,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  rd_src_in,
    output logic        busy,
    output logic        done,
    output logic        reg_we,
    output logic [4:0]  rd_src,
    output logic [31:0] rd
);
    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
    state_t state, state_nx;
    logic [4:0]  cnt;
    logic [4:0]  dst;
    logic [2:0]  f3;
    logic        sa, sb;
    logic [31:0] mag_b;
    logic [63:0] acc;
    logic        div_in, sgn_a_in, sgn_b_in, b_zero, ovf, special;
    logic [31:0] mag_a_in, mag_b_in, spec_res;
    logic [32:0] mul_sum, div_t, div_d;
    logic [63:0] step, prod;
    logic [31:0] quo, rem, res;
    assign div_in   = funct3[2];
    assign sgn_a_in = op_a[31] & (div_in ? !funct3[0] : funct3[1:0] != 2'b11);
    assign sgn_b_in = op_b[31] & (div_in ? !funct3[0] : !funct3[1]);
    assign mag_a_in = sgn_a_in ? -op_a : op_a;
    assign mag_b_in = sgn_b_in ? -op_b : op_b;
    assign b_zero   = op_b == 32'd0;
    assign ovf      = !funct3[0] && op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF;
    assign special  = div_in && (b_zero || ovf);
    assign spec_res = b_zero ? (funct3[1] ? op_a : 32'hFFFF_FFFF) : (funct3[1] ? 32'd0 : 32'h8000_0000);
    // acc holds {partial product hi, multiplier} or {remainder, dividend/quotient}
    assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_b} : 33'd0);
    assign div_t   = {acc[63:32], acc[31]};
    assign div_d   = div_t - {1'b0, mag_b};
    assign step    = f3[2] ? {div_d[32] ? div_t[31:0] : div_d[31:0], acc[30:0], !div_d[32]}
                           : {mul_sum, acc[31:1]};
    assign prod = (sa ^ sb) ? -acc : acc;
    assign quo  = (sa ^ sb) ? -acc[31:0] : acc[31:0];
    assign rem  = sa ? -acc[63:32] : acc[63:32];
    assign res  = f3[2] ? (f3[1] ? rem : quo) : (f3[1:0] == 2'b00 ? prod[31:0] : prod[63:32]);
    assign busy   = state != IDLE;
    assign done   = state == DONE;
    assign reg_we = done && rd_src != 5'd0;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = start ? (special ? DONE : CALC) : IDLE;
            CALC:  state_nx = kill ? IDLE : (cnt == 5'd31 ? FIXUP : CALC);
            FIXUP: state_nx = kill ? IDLE : DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 5'd0;
            dst    <= 5'd0;
            f3     <= 3'd0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            mag_b  <= 32'd0;
            acc    <= 64'd0;
            rd     <= 32'd0;
            rd_src <= 5'd0;
        end else if (state == IDLE && start) begin
            f3    <= funct3;
            dst   <= rd_src_in;
            sa    <= sgn_a_in;
            sb    <= sgn_b_in;
            mag_b <= mag_b_in;
            acc   <= {32'd0, mag_a_in};
            cnt   <= 5'd0;
            if (special) begin
                rd     <= spec_res;
                rd_src <= rd_src_in;
            end
        end else if (state == CALC) begin
            acc <= step;
            cnt <= cnt + 5'd1;
        end else if (state == FIXUP && !kill) begin
            rd     <= res;
            rd_src <= dst;
        end
    end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: table-driven directed checks of mdu results, latency, handshake, kill and reset.
module tb_mdu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic [4:0]  rd_src_in = 5'd0;
    logic        busy, done, reg_we;
    logic [4:0]  rd_src;
    logic [31:0] rd;
    int n_cmp = 0;
    int n_err = 0;

    mdu dut (
        .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .rd_src_in(rd_src_in), .busy(busy), .done(done),
        .reg_we(reg_we), .rd_src(rd_src), .rd(rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  d;
        logic [31:0] exp;
        int          lat;
    } vec_t;
    vec_t v[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Issues one op at a negedge; returns the cycle offset of done (40 when done never rises).
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input int poke, input int kill_at,
                         output int lat, output logic seen, output logic b1, output logic bk);
        funct3 = f; op_a = a; op_b = b; rd_src_in = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat = 1; b1 = busy; bk = 1'b1;
        while (!done && lat < 40) begin
            if (lat == poke) begin
                start = 1'b1; funct3 = 3'b101; op_a = 32'd0; op_b = 32'd0; rd_src_in = 5'd9;
            end else start = 1'b0;
            kill = lat == kill_at;
            @(negedge clk);
            lat++;
            if (lat == kill_at + 1) bk = busy;
        end
        start = 1'b0; kill = 1'b0; seen = done;
    endtask

    initial begin
        int lat;
        logic seen, b1, bk;
        v[0]  = '{3'b000, 32'd7,          32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 34};
        v[1]  = '{3'b001, 32'h80000000,   32'h80000000, 5'd1,  32'h40000000, 34};
        v[2]  = '{3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 34};
        v[3]  = '{3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 34};
        v[4]  = '{3'b100, 32'hFFFFFFF9,   32'd2,        5'd4,  32'hFFFFFFFD, 34};
        v[5]  = '{3'b110, 32'hFFFFFFF9,   32'd2,        5'd6,  32'hFFFFFFFF, 34};
        v[6]  = '{3'b101, 32'd100,        32'd7,        5'd7,  32'd14,       34};
        v[7]  = '{3'b111, 32'd100,        32'd7,        5'd8,  32'd2,        34};
        v[8]  = '{3'b100, 32'd5,          32'd0,        5'd9,  32'hFFFFFFFF, 1};
        v[9]  = '{3'b111, 32'd5,          32'd0,        5'd10, 32'd5,        1};
        v[10] = '{3'b100, 32'h80000000,   32'hFFFFFFFF, 5'd11, 32'h80000000, 1};
        v[11] = '{3'b110, 32'h80000000,   32'hFFFFFFFF, 5'd12, 32'd0,        1};
        v[12] = '{3'b000, 32'd3,          32'd5,        5'd0,  32'd15,       34};
        v[13] = '{3'b101, 32'h80000000,   32'hFFFFFFFF, 5'd13, 32'd0,        34};
        v[14] = '{3'b110, 32'd5,          32'hFFFFFFFD, 5'd14, 32'd2,        34};
        v[15] = '{3'b001, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd15, 32'd0,        34};
        v[16] = '{3'b101, 32'd5,          32'd0,        5'd16, 32'hFFFFFFFF, 1};
        v[17] = '{3'b110, 32'd5,          32'd0,        5'd17, 32'd5,        1};
        repeat (2) @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset reg_we", {31'd0, reg_we}, 32'd0);
        chk("reset rd_src", {27'd0, rd_src}, 32'd0);
        chk("reset rd", rd, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            do_op(v[i].f, v[i].a, v[i].b, v[i].d, -1, -1, lat, seen, b1, bk);
            chk($sformatf("v%0d latency", i), 32'(lat), 32'(v[i].lat));
            chk($sformatf("v%0d rd", i), rd, v[i].exp);
            chk($sformatf("v%0d rd_src", i), {27'd0, rd_src}, {27'd0, v[i].d});
            chk($sformatf("v%0d reg_we", i), {31'd0, reg_we}, {31'd0, v[i].d != 5'd0});
            chk($sformatf("v%0d busy N+1", i), {31'd0, b1}, 32'd1);
            @(negedge clk);
            chk($sformatf("v%0d done pulse", i), {31'd0, done}, 32'd0);
            chk($sformatf("v%0d busy after", i), {31'd0, busy}, 32'd0);
        end
        do_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, 5, -1, lat, seen, b1, bk);
        chk("poke latency", 32'(lat), 32'd34);
        chk("poke rd", rd, 32'hFFFFFFEB);
        chk("poke rd_src", {27'd0, rd_src}, 32'd5);
        @(negedge clk);
        chk("poke no requeue", {31'd0, busy}, 32'd0);
        do_op(3'b101, 32'd100, 32'd7, 5'd4, -1, 10, lat, seen, b1, bk);
        chk("kill no done", {31'd0, seen}, 32'd0);
        chk("kill idle N+11", {31'd0, bk}, 32'd0);
        chk("kill rd kept", rd, 32'hFFFFFFEB);
        chk("kill rd_src kept", {27'd0, rd_src}, 32'd5);
        funct3 = 3'b000; op_a = 32'd7; op_b = 32'd3; rd_src_in = 5'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst busy", {31'd0, busy}, 32'd0);
        chk("arst done", {31'd0, done}, 32'd0);
        chk("arst reg_we", {31'd0, reg_we}, 32'd0);
        chk("arst rd_src", {27'd0, rd_src}, 32'd0);
        chk("arst rd", rd, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("arst no write", {30'd0, done, reg_we}, 32'd0);
        do_op(3'b011, 32'd3, 32'd5, 5'd1, -1, -1, lat, seen, b1, bk);
        chk("post mulhu latency", 32'(lat), 32'd34);
        chk("post mulhu rd", rd, 32'd0);
        @(negedge clk);
        do_op(3'b000, 32'd3, 32'd5, 5'd2, -1, -1, lat, seen, b1, bk);
        chk("post mul latency", 32'(lat), 32'd34);
        chk("post mul rd", rd, 32'd15);
        chk("post mul reg_we", {31'd0, reg_we}, 32'd1);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mdu.md
# mdu

Iterative RV32M multiply/divide unit for the rv32i core. It sits between the register file read ports (`op_a`/`op_b` carry rs1/rs2) and the register file write port (`reg_we`/`rd_src`/`rd` connect directly to it). It executes all eight M-extension ops over multiple cycles with a start/done handshake. The decode/stall logic holds the pipeline while `busy` is high.

## Interface
Parameters:
- none (XLEN fixed at 32, iteration count fixed at 32)

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request a new op; sampled only in IDLE.
- `kill` in 1: synchronous abort of an in-flight op (pipeline flush).
- `funct3` in 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a` in 32: rs1 value.
- `op_b` in 32: rs2 value.
- `rd_src_in` in 5: destination register index.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `reg_we` out 1: register file write enable (active-high, `ENABLE`).
- `rd_src` out 5: destination index for the write.
- `rd` out 32: result.

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- **IDLE, start=1:** latch `funct3`, `rd_src_in` and both operands (sign-handled magnitudes plus sign flags), then clear the iteration counter.
  - Divide special cases go straight to DONE with a fixed result:
    - `op_b`==0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give `op_a`.
    - DIV/REM with `op_a`=0x80000000 and `op_b`=0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
  - Otherwise go to CALC.
- **CALC:** 32 iterations, one per cycle, counter 0..31. Go to FIXUP after iteration 31.
  - Multiply: shift-add of 32-bit magnitudes into a 64-bit product.
  - Divide: restoring division producing a 32-bit quotient and remainder.
- **Signedness:**
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: `op_a` signed, `op_b` unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- **FIXUP:** apply signs, select the result and register it into `rd`/`rd_src`, then go to DONE.
  - Product negated if the operand signs differ.
  - Quotient sign = sign_a XOR sign_b.
  - Remainder sign = sign_a (dividend).
  - MUL takes product[31:0]. MULH, MULHSU and MULHU take product[63:32].
- **DONE:** `done`=1. `reg_we`=1 only if `rd_src`!=0. Return to IDLE next cycle.
- `start` is ignored while `busy`=1. No queuing.
- **kill** in CALC/FIXUP: go to IDLE next edge with no `done` and no `reg_we`; `rd`/`rd_src` keep their previous values. `kill` in IDLE or DONE has no effect; the DONE write still happens.
- `rd` and `rd_src` are registered and hold their value until the next FIXUP or special-case load.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `reg_we`=0, `rd_src`=0, `rd`=0, counter 0.
- Reset mid-op discards the op immediately (asynchronous) and produces no write.
- Normal op, `start` high in cycle N:
  - CALC in cycles N+1..N+32.
  - FIXUP in N+33.
  - DONE (`done`, `reg_we`) in N+34, exactly one cycle.
- Special-case divide: DONE in cycle N+1.
- `busy` rises in N+1 and falls in the cycle after DONE.
- The earliest next accepted `start` is the cycle after DONE.
- `done`, `reg_we`, `rd` and `rd_src` are valid together in the DONE cycle. The register file captures them at the end of that cycle.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), `start` in cycle N, `rd_src_in`=5 -> `rd`=0xFFFFFFEB, `rd_src`=5, `done`/`reg_we` high only in N+34, `busy` high in N+1..N+34.
- Upper halves:
  - MULH 0x80000000×0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- Signed/unsigned divide: DIV −7/2 -> 0xFFFFFFFD; REM −7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; all complete at N+34.
- Special cases: DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0; each has `done` in N+1.
- Handshake and abort:
  - `start` pulsed during CALC -> ignored; the original result is unchanged.
  - `kill` in cycle N+10 -> IDLE in N+11, no `done`, `rd` unchanged.
  - `rd_src_in`=0 -> `done`=1 with `reg_we`=0.
- `rst_n` low in cycle N+20 -> all outputs 0 asynchronously with no write. After release, MULHU 3×5 -> 0 and MUL 3×5 -> 15, both correct.
